// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the time-multiplexed FIR filter.
//   - state_t   : controller state encoding (IDLE / MAC / OUT)
//   - clog2()   : ceiling log2 used to size the coefficient address
//   - *_DEF     : default widths and tap count for the filter
package fir_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int TAPS_DEF   = 25;
  localparam int OUT_W_DEF  = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: TAPS x COEF_W coefficient register file.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (clears all coefficients)
//   i_flush        flush in progress: write ignored, no error raised
//   i_busy         filter is computing or holding a result: writes are dropped
//   i_we, i_addr, i_data   write port, applied on the clock edge
//   i_rd_idx, o_coef       combinational read port (tap index of the MAC)
//   o_err          one-cycle pulse the cycle after a dropped write
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAPS   = TAPS_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_busy,
  input  logic                   i_we,
  input  logic [clog2(TAPS)-1:0] i_addr,
  input  logic [COEF_W-1:0]      i_data,
  input  logic [clog2(TAPS)-1:0] i_rd_idx,
  output logic [COEF_W-1:0]      o_coef,
  output logic                   o_err
);

  logic [COEF_W-1:0] r_coef [TAPS];
  logic              r_err;
  logic [31:0]       w_addr_ext;
  logic              w_addr_ok;
  logic              w_wr;
  logic              w_drop;

  // Range check is done on a widened copy so it stays meaningful when TAPS
  // is a power of two and every address value is in range.
  always_comb begin
    w_addr_ext = 32'(i_addr);
    w_addr_ok  = (w_addr_ext < 32'(TAPS));
    w_wr       = i_we & ~i_flush & ~i_busy & w_addr_ok;
    w_drop     = i_we & ~i_flush & (i_busy | ~w_addr_ok);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_drop;
      if (w_wr) r_coef[i_addr] <= i_data;
    end
  end

  assign o_coef = r_coef[i_rd_idx];
  assign o_err  = r_err;

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR filter, one signed MAC per clock.
// A sample accepted in IDLE is shifted into the delay line, then TAPS MAC
// cycles accumulate x[k]*coef[k]; the formatted result is held in OUT until
// the downstream handshake completes.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   flush              synchronous clear of delay line and in-flight work
//   in_valid/in_ready/data_in      sample input handshake
//   out_valid/out_ready/data_out   result output handshake (data_out registered)
//   coef_we/coef_addr/coef_in      coefficient write port (IDLE only)
//   coef_err           one-cycle pulse: coefficient write dropped
//   busy               high in MAC or OUT
//   sat_flag           (FIR_SAT_EN only) result was clipped
// Build option: define FIR_SAT_EN to saturate the shifted accumulator to the
// OUT_W signed range instead of wrapping.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int ACC_W  = DATA_W + COEF_W + clog2(TAPS),
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       data_out,
  input  logic                   coef_we,
  input  logic [clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]      coef_in,
  output logic                   coef_err,
  output logic                   busy
`ifdef FIR_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int AW = clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [AW-1:0]             r_idx;
  logic signed [DATA_W-1:0]  r_x [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_out_valid;
  logic [OUT_W-1:0]          r_data_out;
  logic [COEF_W-1:0]         w_coef_raw;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PW-1:0]      w_prod;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic [OUT_W-1:0]          w_fmt;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_busy;

  function automatic logic signed [ACC_W-1:0] acc_shift(input logic signed [ACC_W-1:0] a);
    return a >>> SHIFT;
  endfunction

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic r_sat;
  logic w_clip;

  function automatic logic is_clip(input logic signed [ACC_W-1:0] a);
    return (acc_shift(a) > SAT_MAX) || (acc_shift(a) < SAT_MIN);
  endfunction

  function automatic logic [OUT_W-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    if (acc_shift(a) > SAT_MAX) return OUT_W'(SAT_MAX);
    if (acc_shift(a) < SAT_MIN) return OUT_W'(SAT_MIN);
    return OUT_W'(acc_shift(a));
  endfunction
`else
  function automatic logic [OUT_W-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    return OUT_W'(acc_shift(a));
  endfunction
`endif

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_flush  (flush),
    .i_busy   (w_busy),
    .i_we     (coef_we),
    .i_addr   (coef_addr),
    .i_data   (coef_in),
    .i_rd_idx (r_idx),
    .o_coef   (w_coef_raw),
    .o_err    (coef_err)
  );

  // Coefficient writes take priority over samples, and flush over both.
  always_comb begin
    w_busy    = (r_state == MAC) || (r_state == OUT);
    w_accept  = (r_state == IDLE) & ~flush & ~coef_we & in_valid;
    w_last    = (r_idx == AW'(TAPS - 1));
    w_coef    = signed'(w_coef_raw);
    w_prod    = r_x[r_idx] * w_coef;
    w_acc_sum = r_acc + ACC_W'(w_prod);
    w_fmt     = fmt_out(w_acc_sum);
`ifdef FIR_SAT_EN
    w_clip    = is_clip(w_acc_sum);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = MAC;
        MAC:     if (w_last) w_state_nxt = OUT;
        OUT:     if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs; in_ready is masked by reset so every output reads 0 in reset.
  always_comb begin
    in_ready  = (r_state == IDLE) & ~coef_we & ~reset;
    busy      = w_busy;
    out_valid = r_out_valid;
    data_out  = r_data_out;
`ifdef FIR_SAT_EN
    sat_flag  = r_sat;
`endif
  end

  // Delay line, accumulator and result register. The final MAC edge both
  // completes the sum and registers the formatted result, so out_valid is
  // up as soon as the controller enters OUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
`ifdef FIR_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
`ifdef FIR_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0] <= signed'(data_in);
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        MAC: begin
          r_acc <= w_acc_sum;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_data_out  <= w_fmt;
`ifdef FIR_SAT_EN
            r_sat       <= w_clip;
`endif
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
`ifdef FIR_SAT_EN
            r_sat       <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Testbench for fir_mac_seq. Instance dut_a (TAPS=4, OUT_W=18) is checked
// every cycle against a sample-history model; instance dut_b (TAPS=5,
// OUT_W=8) covers out-of-range coefficient addresses and output wrap or
// saturation (FIR_SAT_EN).
module tb_fir_mac_seq;

  localparam int TA = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, coef_we = 1'b0;
  logic [7:0] data_in = '0, coef_in = '0;
  logic [1:0] coef_addr = '0;
  logic       in_ready, out_valid, coef_err, busy;
  logic [17:0] data_out;

  logic       b_in_valid = 1'b0, b_coef_we = 1'b0;
  logic [7:0] b_data_in = '0, b_coef_in = '0;
  logic [2:0] b_coef_addr = '0;
  logic       b_in_ready, b_out_valid, b_coef_err, b_busy;
  logic [7:0] b_data_out;
`ifdef FIR_SAT_EN
  logic       sat_a, sat_b;
`endif

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int cap_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_mac_seq #(.DATA_W(8), .COEF_W(8), .TAPS(TA), .OUT_W(18), .SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_in(coef_in), .coef_err(coef_err),
    .busy(busy)
`ifdef FIR_SAT_EN
    , .sat_flag(sat_a)
`endif
  );

  fir_mac_seq #(.DATA_W(8), .COEF_W(8), .TAPS(5), .OUT_W(8), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .out_valid(b_out_valid), .out_ready(1'b1), .data_out(b_data_out),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_in(b_coef_in), .coef_err(b_coef_err),
    .busy(b_busy)
`ifdef FIR_SAT_EN
    , .sat_flag(sat_b)
`endif
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model of dut_a: sample history + result timing -------
  int         m_coef[TA];
  int         m_hist[TA];
  bit         m_pend;     // a sample is accepted and its result not yet taken
  int         m_age;      // edges since acceptance
  int         m_exp;
  logic [17:0] m_last;    // last result presented on data_out
  bit         m_err;
  bit         m_idle;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TA; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
      m_pend = 0; m_age = 0; m_exp = 0; m_last = '0; m_err = 0;
    end else begin
      m_idle = !m_pend;
      m_err  = 0;
      if (flush) begin
        for (int k = 0; k < TA; k++) m_hist[k] = 0;
        m_pend = 0; m_age = 0;
      end else begin
        if (m_pend) begin
          if (m_age >= TA && out_ready) m_pend = 0;
          else begin
            m_age++;
            if (m_age == TA) m_last = 18'(m_exp);
          end
        end
        if (coef_we) begin
          if (m_idle && int'(coef_addr) < TA) m_coef[coef_addr] = int'($signed(coef_in));
          else m_err = 1;
        end else if (in_valid && m_idle) begin
          for (int k = TA - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
          m_hist[0] = int'($signed(data_in));
          m_exp = 0;
          for (int k = 0; k < TA; k++) m_exp += m_coef[k] * m_hist[k];
          m_pend = 1; m_age = 0;
        end
      end
    end
  end

  // Compare dut_a against the model on every falling edge.
  always @(negedge clk) begin
    chk("in_ready",  in_ready,  (!reset && !m_pend && !coef_we));
    chk("busy",      busy,      m_pend);
    chk("out_valid", out_valid, (m_pend && m_age >= TA));
    chk("coef_err",  coef_err,  m_err);
    chk("data_out",  data_out,  m_last);
`ifdef FIR_SAT_EN
    chk("sat_flag_a", sat_a, 0);
`endif
    if (!reset && out_valid && out_ready) cap_q.push_back(int'($signed(data_out)));
  end

  // ---------------- drivers ----------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_a(input int addr, input int val);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_in = 8'(val);
    tick(1);
    coef_we = 1'b0;
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick(1); n++; end
    if (!in_ready) chk("wait_in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_a(output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); lat++;
      if (out_valid) break;
    end
    if (!out_valid) chk("wait_out_valid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Present v, return the accept cycle and the number of falling edges from
  // the accepting edge up to the first one showing out_valid.
  task automatic send_a(input int v, output int acc_cyc, output int lat);
    wait_ready_a();
    in_valid = 1'b1; data_in = 8'(v);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    wait_out_a(lat);
  endtask

  int lat, c0, c1, base, cnt, seen;
  int b_out[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_data_out", data_out, 0);
    reset = 1'b0;
    tick(1);

    // Impulse response with coefs {1,2,3,4}
    for (int k = 0; k < TA; k++) wr_a(k, k + 1);
    send_a(1, c0, lat);
    chk("latency_cycles", lat, 5);
    for (int k = 0; k < 4; k++) send_a(0, c0, lat);
    tick(1);
    chk("impulse_count", cap_q.size(), 5);
    if (cap_q.size() >= 5) begin
      chk("impulse_0", cap_q[0], 1); chk("impulse_1", cap_q[1], 2);
      chk("impulse_2", cap_q[2], 3); chk("impulse_3", cap_q[3], 4);
      chk("impulse_4", cap_q[4], 0);
    end

    // Signed arithmetic, back-to-back throughput
    for (int k = 0; k < TA; k++) wr_a(k, -1);
    base = cap_q.size();
    send_a(127, c0, lat);
    send_a(127, c0, lat);
    send_a(127, c1, lat);
    chk("accept_spacing", c1 - c0, TA + 2);
    send_a(127, c0, lat);
    tick(1);
    if (cap_q.size() >= base + 4) begin
      chk("neg_0", cap_q[base], -127); chk("neg_1", cap_q[base+1], -254);
      chk("neg_2", cap_q[base+2], -381); chk("neg_3", cap_q[base+3], -508);
    end else chk("neg_count", cap_q.size() - base, 4);

    // Coefficient write while computing is dropped, result unaffected
    for (int k = 0; k < TA; k++) wr_a(k, k + 1);
    wait_ready_a();
    in_valid = 1'b1; data_in = 8'd1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    coef_we = 1'b1; coef_addr = 2'd0; coef_in = 8'd99;
    tick(1);
    coef_we = 1'b0;
    @(negedge clk);
    chk("coef_err_pulse", coef_err, 1);
    wait_out_a(lat);
    tick(1);
    chk("mac_write_result", cap_q[$], 1144);

    // Output stall: held result, no second accept
    out_ready = 1'b0;
    base = cap_q.size();
    send_a(0, c0, lat);
    in_valid = 1'b1; data_in = 8'd77;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", $signed(data_out), 891);
      chk("stall_in_ready", in_ready, 0);
    end
    tick(1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(3);
    chk("stall_count", cap_q.size() - base, 1);
    chk("stall_result", cap_q[$], 891);

    // Flush during MAC idx=2
    base = cap_q.size();
    wait_ready_a();
    in_valid = 1'b1; data_in = 8'd5;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin @(negedge clk); if (out_valid) seen++; end
    chk("flush_no_valid", seen, 0);
    chk("flush_count", cap_q.size() - base, 0);
    // flush beats a same-cycle sample and coefficient write
    tick(1);
    flush = 1'b1; in_valid = 1'b1; data_in = 8'd9;
    coef_we = 1'b1; coef_addr = 2'd0; coef_in = 8'd50;
    tick(1);
    flush = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    chk("flush_beats_busy", busy, 0);
    send_a(1, c0, lat);
    for (int k = 0; k < 3; k++) send_a(0, c0, lat);
    tick(1);
    if (cap_q.size() >= base + 4) begin
      chk("post_flush_0", cap_q[base], 1); chk("post_flush_1", cap_q[base+1], 2);
      chk("post_flush_2", cap_q[base+2], 3); chk("post_flush_3", cap_q[base+3], 4);
    end else chk("post_flush_count", cap_q.size() - base, 4);

    // dut_b: out-of-range address, then wrap / saturation
    for (int k = 0; k < 4; k++) begin
      b_coef_we = 1'b1; b_coef_addr = 3'(k); b_coef_in = 8'd127;
      tick(1);
    end
    b_coef_addr = 3'd7; b_coef_in = 8'd55;
    tick(1);
    b_coef_we = 1'b0;
    @(negedge clk);
    chk("b_coef_err_range", b_coef_err, 1);
    tick(1);
    chk("b_coef_err_clear", b_coef_err, 0);
    for (int s = 0; s < 4; s++) begin
      cnt = 0;
      while (!b_in_ready && cnt < 40) begin tick(1); cnt++; end
      b_in_valid = 1'b1; b_data_in = 8'd127;
      tick(1);
      b_in_valid = 1'b0;
      cnt = 0;
      while (!b_out_valid && cnt < 40) begin @(negedge clk); cnt++; end
      chk("b_out_valid", b_out_valid, 1);
      b_out.push_back(int'($signed(b_data_out)));
`ifdef FIR_SAT_EN
      chk("b_sat_flag", sat_b, 1);
`endif
      tick(1);
    end
    for (int s = 0; s < b_out.size(); s++) begin
`ifdef FIR_SAT_EN
      chk("b_saturated", b_out[s], 127);
`else
      chk("b_wrapped", b_out[s], s + 1);
`endif
    end

    // Reset in the middle of MAC aborts the computation
    wait_ready_a();
    in_valid = 1'b1; data_in = 8'd3;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); if (out_valid) seen++; end
    chk("reset_abort_no_valid", seen, 0);
    chk("reset_abort_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
